// File: rtl/puf2usrp_pkg.sv
// Shared definitions for the puf2usrp front-end: scheduler states, grant codes, default sample width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package puf2usrp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      BURST = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic GRANT_S0 = 1'b0;
   localparam logic GRANT_S1 = 1'b1;

   // Width of one I or Q component; a sample is {I,Q}.
   localparam int DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/puf2usrp_rr_arb2.sv
// Two-way requester arbiter: fixed priority (s0 first) or alternate against the last winner.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module puf2usrp_rr_arb2
   import puf2usrp_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio_fixed,
   input  logic       last_grant,
   output logic       gnt,
   output logic       gnt_valid
);

   // Pick a winner; with both requesting, round-robin hands the burst to the one that did not win last.
   always_comb begin
      gnt       = GRANT_S0;
      gnt_valid = |req;
      case (req)
         2'b01:   gnt = GRANT_S0;
         2'b10:   gnt = GRANT_S1;
         2'b11:   gnt = prio_fixed ? GRANT_S0 : ~last_grant;
         default: gnt = GRANT_S0;
      endcase
   end

endmodule

// File: rtl/puf2usrp_burst_sched.sv
// Burst scheduler sharing the puf2usrp sample input between s0 (PUF) and s1 (calibration) streams.
// Latency: zero-cycle pass-through datapath; one ARB cycle between bursts plus cfg_gap idle cycles.
// Backpressure: out_tready goes straight to the granted source's tready; the other source sees 0.
module puf2usrp_burst_sched
   import puf2usrp_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH  = 16,
   parameter int GAP_WIDTH  = 8
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cfg_enable,
   input  logic                    cfg_prio,
   input  logic [LEN_WIDTH-1:0]    cfg_burst_len,
   input  logic [GAP_WIDTH-1:0]    cfg_gap,
   input  logic                    cfg_abort,
   input  logic [2*DATA_WIDTH-1:0] s0_tdata,
   input  logic                    s0_tvalid,
   output logic                    s0_tready,
   input  logic [2*DATA_WIDTH-1:0] s1_tdata,
   input  logic                    s1_tvalid,
   output logic                    s1_tready,
   output logic [2*DATA_WIDTH-1:0] out_tdata,
   output logic                    out_tvalid,
   output logic                    out_tlast,
   input  logic                    out_tready,
   output logic                    stat_busy,
   output logic                    stat_grant,
   output logic [31:0]             stat_bursts
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
   localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

   state_t                  state_q, state_d;
   logic                    grant_q;
   logic                    last_grant_q;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [LEN_WIDTH-1:0]    beat_cnt_q;
   logic [GAP_WIDTH-1:0]    gap_cnt_q;
   logic                    abort_pend_q;
   logic [31:0]             bursts_q;

   logic                    arb_gnt;
   logic                    arb_vld;
   logic                    in_burst;
   logic                    take_grant;
   logic                    beat_last;
   logic                    hs;
   logic                    end_burst;
   logic [LEN_WIDTH-1:0]    len_lat;

   puf2usrp_rr_arb2 u_arb (
      .req        ({s1_tvalid, s0_tvalid}),
      .prio_fixed (cfg_prio),
      .last_grant (last_grant_q),
      .gnt        (arb_gnt),
      .gnt_valid  (arb_vld)
   );

   // Datapath mux, handshake and last-beat detection; everything is forced to 0 outside a burst.
   always_comb begin
      in_burst   = (state_q == BURST);
      take_grant = (state_q == ARB) & cfg_enable & arb_vld;
      len_lat    = (cfg_burst_len == '0) ? LEN_ONE : cfg_burst_len;
      // A same-cycle abort already marks the current beat as the last one.
      beat_last  = in_burst & ((beat_cnt_q == len_q - LEN_ONE) | abort_pend_q | cfg_abort);
      out_tvalid = in_burst & (grant_q ? s1_tvalid : s0_tvalid);
      out_tdata  = in_burst ? (grant_q ? s1_tdata : s0_tdata) : '0;
      out_tlast  = beat_last;
      s0_tready  = in_burst & (grant_q == GRANT_S0) & out_tready;
      s1_tready  = in_burst & (grant_q == GRANT_S1) & out_tready;
      hs         = out_tvalid & out_tready;
      end_burst  = hs & beat_last;
      stat_busy  = (state_q == BURST) | (state_q == GAP);
      stat_grant = grant_q;
      stat_bursts = bursts_q;
   end

   // Next-state logic: disable is only honoured at burst/gap boundaries, never mid-burst.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cfg_enable) state_d = ARB;
         end
         ARB: begin
            if (!cfg_enable)  state_d = IDLE;
            else if (arb_vld) state_d = BURST;
         end
         BURST: begin
            if (end_burst) begin
               if (cfg_gap != '0)   state_d = GAP;
               else if (cfg_enable) state_d = ARB;
               else                 state_d = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt_q <= GAP_ONE) state_d = cfg_enable ? ARB : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Grant and burst length are captured once per burst; beat counter stays within 0..len-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_q    <= GRANT_S0;
         len_q      <= LEN_ONE;
         beat_cnt_q <= '0;
      end else if (take_grant) begin
         grant_q    <= arb_gnt;
         len_q      <= len_lat;
         beat_cnt_q <= '0;
      end else if (hs) begin
         beat_cnt_q <= end_burst ? '0 : beat_cnt_q + LEN_ONE;
      end
   end

   // Abort request sticks until the burst's final beat is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   abort_pend_q <= 1'b0;
      else if (end_burst)             abort_pend_q <= 1'b0;
      else if (in_burst && cfg_abort) abort_pend_q <= 1'b1;
   end

   // Gap counter loads on the last beat and counts down while idling between bursts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               gap_cnt_q <= '0;
      else if (end_burst)         gap_cnt_q <= cfg_gap;
      else if (state_q == GAP)    gap_cnt_q <= gap_cnt_q - GAP_ONE;
   end

   // Completed-burst statistics and round-robin history; last_grant starts at s1 so s0 wins first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bursts_q     <= '0;
         last_grant_q <= GRANT_S1;
      end else if (end_burst) begin
         bursts_q     <= bursts_q + 32'd1;
         last_grant_q <= grant_q;
      end
   end

endmodule

// File: tb/tb_puf2usrp_burst_sched.sv
`timescale 1ns/1ps
module tb_puf2usrp_burst_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_enable, cfg_prio, cfg_abort;
   logic [15:0] cfg_burst_len;
   logic [7:0]  cfg_gap;
   logic [31:0] s0_tdata, s1_tdata, out_tdata;
   logic        s0_tvalid, s1_tvalid, s0_tready, s1_tready;
   logic        out_tvalid, out_tlast, out_tready;
   logic        stat_busy, stat_grant;
   logic [31:0] stat_bursts;

   int checks = 0;
   int errors = 0;
   int s0_cnt = 0;
   int s1_cnt = 0;
   logic rdy_toggle = 1'b0;

   always #5 clk = ~clk;

   puf2usrp_burst_sched dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_enable(cfg_enable), .cfg_prio(cfg_prio), .cfg_burst_len(cfg_burst_len),
      .cfg_gap(cfg_gap), .cfg_abort(cfg_abort),
      .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
      .out_tready(out_tready),
      .stat_busy(stat_busy), .stat_grant(stat_grant), .stat_bursts(stat_bursts)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock per iteration; sources advance their sample only after an accepted beat.
   task automatic step(input int n);
      logic h0, h1;
      for (int i = 0; i < n; i++) begin
         #1;
         h0 = s0_tvalid & s0_tready;
         h1 = s1_tvalid & s1_tready;
         @(posedge clk);
         #1;
         if (h0) s0_cnt++;
         if (h1) s1_cnt++;
         s0_tdata = 32'hA000_0000 + 32'(s0_cnt);
         s1_tdata = 32'hB000_0000 + 32'(s1_cnt);
         if (rdy_toggle) out_tready = ~out_tready;
      end
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      cfg_enable = 1'b0;
      cfg_abort  = 1'b0;
      rdy_toggle = 1'b0;
      out_tready = 1'b1;
      s0_cnt     = 0;
      s1_cnt     = 0;
      s0_tdata   = 32'hA000_0000;
      s1_tdata   = 32'hB000_0000;
      step(2);
      reset_n = 1'b1;
      step(1);
   endtask

   // Behavioural model: bursts as transactions (source, length, beat index, spacing).
   initial begin : monitor
      int         cyc, m_beat, m_len, m_gap, t_last;
      logic       m_inburst, m_src, m_last, m_abort, m_armed, exp_last;
      logic [31:0] m_bursts, p_dat;
      logic       p_vld, p_rdy, p_lst;
      cyc = 0; m_beat = 0; m_len = 1; m_gap = 0; t_last = 0;
      m_inburst = 0; m_src = 0; m_last = 1; m_abort = 0; m_armed = 0;
      m_bursts = 0; p_dat = 0; p_vld = 0; p_rdy = 0; p_lst = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            m_inburst = 0; m_last = 1; m_abort = 0; m_armed = 0; m_beat = 0;
            m_bursts = 0; p_vld = 0;
            chk("reset_ctl", 32'({out_tvalid, out_tlast, s0_tready, s1_tready, stat_busy, stat_grant}), 32'd0);
            chk("reset_dat", out_tdata, 32'd0);
            chk("reset_bursts", stat_bursts, 32'd0);
         end else begin
            if (!cfg_enable || !(s0_tvalid || s1_tvalid)) m_armed = 0;
            if (out_tvalid && !m_inburst) begin
               m_inburst = 1; m_beat = 0; m_abort = 0;
               m_len = (cfg_burst_len == 16'd0) ? 1 : int'(cfg_burst_len);
               if (s0_tvalid && s1_tvalid) m_src = cfg_prio ? 1'b0 : ~m_last;
               else                        m_src = s1_tvalid;
               if (m_armed) chk("gap_spacing", 32'(cyc - t_last), 32'(m_gap + 2));
               m_armed = 0;
            end
            if (m_inburst && cfg_abort) m_abort = 1;
            chk("bursts", stat_bursts, m_bursts);
            if (m_inburst) begin
               chk("busy", 32'(stat_busy), 32'd1);
               chk("grant", 32'(stat_grant), 32'(m_src));
               chk("rdy_gnt", 32'(m_src ? s1_tready : s0_tready), 32'(out_tready));
               chk("rdy_ungnt", 32'(m_src ? s0_tready : s1_tready), 32'd0);
               if (out_tvalid) begin
                  exp_last = (m_beat == m_len - 1) || m_abort;
                  chk("tdata", out_tdata, m_src ? s1_tdata : s0_tdata);
                  chk("tlast", 32'(out_tlast), 32'(exp_last));
                  if (p_vld && !p_rdy) begin
                     chk("hold_dat", out_tdata, p_dat);
                     chk("hold_last", 32'(out_tlast), 32'(p_lst));
                  end
                  if (out_tready) begin
                     m_beat++;
                     if (exp_last) begin
                        m_bursts  = m_bursts + 32'd1;
                        m_last    = m_src;
                        m_inburst = 0;
                        t_last    = cyc;
                        m_gap     = int'(cfg_gap);
                        m_armed   = cfg_enable && (s0_tvalid || s1_tvalid);
                     end
                  end
               end
            end else begin
               chk("idle_ctl", 32'({out_tvalid, out_tlast, s0_tready, s1_tready}), 32'd0);
               chk("idle_dat", out_tdata, 32'd0);
            end
            p_vld = out_tvalid; p_rdy = out_tready; p_dat = out_tdata; p_lst = out_tlast;
         end
      end
   end

   // Directed scenarios with hand-computed cycle-exact expectations.
   initial begin
      reset_n = 1'b0; cfg_enable = 1'b0; cfg_prio = 1'b0; cfg_abort = 1'b0;
      cfg_burst_len = 16'd4; cfg_gap = 8'd2;
      s0_tvalid = 1'b0; s1_tvalid = 1'b0; out_tready = 1'b1;
      s0_tdata = 32'hA000_0000; s1_tdata = 32'hB000_0000;

      do_reset();
      chk("rst_state", 32'({out_tvalid, stat_busy, stat_grant}), 32'd0);
      chk("rst_cnt", stat_bursts, 32'd0);

      // 1: len 4, gap 2, s0 only: 7-cycle burst period, beat 3 of burst 3 at step 19.
      cfg_burst_len = 16'd4; cfg_gap = 8'd2; s0_tvalid = 1'b1; s1_tvalid = 1'b0; cfg_enable = 1'b1;
      step(19); #1;
      chk("t1_tlast", 32'(out_tlast), 32'd1);
      chk("t1_dat", out_tdata, 32'hA000_000B);
      chk("t1_bursts2", stat_bursts, 32'd2);
      step(1); #1;
      chk("t1_gap", 32'({stat_busy, out_tvalid}), 32'b10);
      chk("t1_bursts3", stat_bursts, 32'd3);

      // 2: both valid, round-robin, len 3, gap 0.
      do_reset();
      cfg_burst_len = 16'd3; cfg_gap = 8'd0; cfg_prio = 1'b0;
      s0_tvalid = 1'b1; s1_tvalid = 1'b1; cfg_enable = 1'b1;
      step(3); #1;
      chk("t2_first_s0", 32'(stat_grant), 32'd0);
      chk("t2_s1_blocked", 32'(s1_tready), 32'd0);
      chk("t2_dat0", out_tdata, 32'hA000_0001);
      step(4); #1;
      chk("t2_second_s1", 32'(stat_grant), 32'd1);
      chk("t2_s0_blocked", 32'(s0_tready), 32'd0);
      chk("t2_dat1", out_tdata, 32'hB000_0001);
      step(12); #1;
      chk("t2_bursts", stat_bursts, 32'd4);
      chk("t2_fifth_s0", 32'(stat_grant), 32'd0);

      // 3: fixed priority, s1 never served.
      do_reset();
      cfg_burst_len = 16'd2; cfg_gap = 8'd1; cfg_prio = 1'b1;
      s0_tvalid = 1'b1; s1_tvalid = 1'b1; cfg_enable = 1'b1;
      step(30); #1;
      chk("t3_bursts", stat_bursts, 32'd7);
      chk("t3_dat", out_tdata, 32'hA000_000E);
      chk("t3_s1_none", 32'(s1_cnt), 32'd0);

      // 4: len 8 with out_tready toggling every cycle.
      do_reset();
      cfg_burst_len = 16'd8; cfg_gap = 8'd0; cfg_prio = 1'b0;
      s0_tvalid = 1'b1; s1_tvalid = 1'b0; out_tready = 1'b1; rdy_toggle = 1'b1; cfg_enable = 1'b1;
      step(34); #1;
      chk("t4_bursts", stat_bursts, 32'd2);
      chk("t4_valid", 32'(out_tvalid), 32'd1);
      chk("t4_dat", out_tdata, 32'hA000_0010);
      rdy_toggle = 1'b0; out_tready = 1'b1;

      // 5a: len 16 aborted on beat 5.
      do_reset();
      cfg_burst_len = 16'd16; cfg_gap = 8'd0;
      s0_tvalid = 1'b1; s1_tvalid = 1'b0; cfg_enable = 1'b1;
      step(7);
      cfg_abort = 1'b1; #1;
      chk("t5_abort_last", 32'(out_tlast), 32'd1);
      chk("t5_abort_dat", out_tdata, 32'hA000_0005);
      step(1);
      cfg_abort = 1'b0; #1;
      chk("t5_abort_cnt", stat_bursts, 32'd1);
      chk("t5_abort_arb", 32'(out_tvalid), 32'd0);
      step(5);

      // 5b: len 0 behaves as single-beat bursts.
      do_reset();
      cfg_burst_len = 16'd0; cfg_gap = 8'd0; cfg_enable = 1'b1;
      step(10); #1;
      chk("t5_len0_cnt", stat_bursts, 32'd4);
      chk("t5_len0_last", 32'({out_tvalid, out_tlast}), 32'b11);

      // 6: disable mid-burst completes the burst, then reset mid-burst clears everything.
      do_reset();
      cfg_burst_len = 16'd6; cfg_gap = 8'd0; cfg_enable = 1'b1;
      step(4);
      cfg_enable = 1'b0;
      step(4); #1;
      chk("t6_done_cnt", stat_bursts, 32'd1);
      chk("t6_idle", 32'({stat_busy, out_tvalid}), 32'd0);
      step(3); #1;
      chk("t6_beats", 32'(s0_cnt), 32'd6);
      cfg_enable = 1'b1;
      step(3); #1;
      chk("t6_pre_reset_vld", 32'(out_tvalid), 32'd1);
      reset_n = 1'b0; #1;
      chk("t6_rst_ctl", 32'({out_tvalid, out_tlast, s0_tready, stat_busy}), 32'd0);
      chk("t6_rst_dat", out_tdata, 32'd0);
      chk("t6_rst_cnt", stat_bursts, 32'd0);
      step(2);
      reset_n = 1'b1;
      step(2); #1;
      chk("t6_post_cnt", stat_bursts, 32'd0);
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
